// File: rtl/sram_arb_pkg.sv
// sram_arb_pkg: shared widths, wait-counter width and FSM state type for the SRAM arbiter
package sram_arb_pkg;
  localparam int ADDR_W = 18;
  localparam int DATA_W = 16;
  localparam int CNT_W  = 4;
  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_e;
endpackage

// File: rtl/sram_arb_grant.sv
// sram_arb_grant: 2-way grant select; round-robin pointer when SRAM_ARB_RR_EN is defined, else port 0 wins
module sram_arb_grant (
`ifdef SRAM_ARB_RR_EN
  input  logic clk,
  input  logic rst,
  input  logic en_i,
`endif
  input  logic req0_i,
  input  logic req1_i,
  output logic gnt_o
);
`ifdef SRAM_ARB_RR_EN
  logic ptr_q;
  // contention goes to the pointer port; a lone requester always wins
  always_comb gnt_o = (req0_i && req1_i) ? ptr_q : req1_i;
  // after every grant the other port gets priority next time
  always_ff @(posedge clk)
    if (rst) ptr_q <= 1'b0;
    else if (en_i) ptr_q <= !gnt_o;
`else
  // port 1 only when port 0 is not asking
  always_comb gnt_o = req1_i && !req0_i;
`endif
endmodule

// File: rtl/sram_arbiter_2port.sv
// sram_arbiter_2port: two-client arbiter and strobe sequencer for a 16x256K async SRAM (SRAM_ARB_RR_EN: round-robin)
module sram_arbiter_2port
  import sram_arb_pkg::*;
#(
  parameter int WAIT_CYCLES = 1
) (
  input  logic              iCLK,
  input  logic              iRST,
  input  logic              iREQ0,
  input  logic              iREQ1,
  input  logic              iWR0,
  input  logic              iWR1,
  input  logic [ADDR_W-1:0] iADDR0,
  input  logic [ADDR_W-1:0] iADDR1,
  input  logic [DATA_W-1:0] iDATA0,
  input  logic [DATA_W-1:0] iDATA1,
  input  logic [1:0]        iBE0_N,
  input  logic [1:0]        iBE1_N,
  output logic [DATA_W-1:0] oDATA0,
  output logic [DATA_W-1:0] oDATA1,
  output logic              oACK0,
  output logic              oACK1,
  output logic [ADDR_W-1:0] oSRAM_ADDR,
  output logic [DATA_W-1:0] oSRAM_WDATA,
  input  logic [DATA_W-1:0] iSRAM_RDATA,
  output logic              oSRAM_CE_N,
  output logic              oSRAM_OE_N,
  output logic              oSRAM_WE_N,
  output logic [1:0]        oSRAM_BE_N
);
  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              sel_q, sel_d, wr_q, wr_d, gnt, grant_go, last_rd;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic [1:0]        be_q, be_d, sbe_n_q, sbe_n_d;
  logic              ce_n_q, ce_n_d, oe_n_q, oe_n_d, we_n_q, we_n_d;
  logic              ack0_q, ack0_d, ack1_q, ack1_d;

  assign grant_go = (state_q == IDLE) && (iREQ0 || iREQ1);

  sram_arb_grant u_grant (
`ifdef SRAM_ARB_RR_EN
    .clk    (iCLK),
    .rst    (iRST),
    .en_i   (grant_go),
`endif
    .req0_i (iREQ0),
    .req1_i (iREQ1),
    .gnt_o  (gnt)
  );

  // state, wait counter, latched request and registered SRAM/host outputs
  always_ff @(posedge iCLK)
    if (iRST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      sel_q    <= 1'b0;
      wr_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= 2'b11;
      sbe_n_q  <= 2'b11;
      ce_n_q   <= 1'b1;
      oe_n_q   <= 1'b1;
      we_n_q   <= 1'b1;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      wr_q     <= wr_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      be_q     <= be_d;
      sbe_n_q  <= sbe_n_d;
      ce_n_q   <= ce_n_d;
      oe_n_q   <= oe_n_d;
      we_n_q   <= we_n_d;
      ack0_q   <= ack0_d;
      ack1_q   <= ack1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end

  // next state, wait countdown, and request capture at grant
  always_comb begin
    state_d = state_q == IDLE   ? (grant_go ? SETUP : IDLE) :
              state_q == SETUP  ? ACCESS :
              state_q == ACCESS ? (cnt_q == '0 ? HOLD : ACCESS) : IDLE;
    cnt_d   = state_q == SETUP  ? CNT_W'(WAIT_CYCLES) :
              state_q == ACCESS ? cnt_q - CNT_W'(1) : cnt_q;
    sel_d   = grant_go ? gnt : sel_q;
    wr_d    = grant_go ? (gnt ? iWR1 : iWR0) : wr_q;
    addr_d  = grant_go ? (gnt ? iADDR1 : iADDR0) : addr_q;
    wdata_d = grant_go ? (gnt ? iDATA1 : iDATA0) : wdata_q;
    be_d    = grant_go ? (gnt ? iBE1_N : iBE0_N) : be_q;
  end

  // outputs are registered from the state being entered so every pin is a flop
  always_comb begin
    last_rd  = state_q == ACCESS && cnt_q == '0 && !wr_q;
    ce_n_d   = state_d == IDLE;
    oe_n_d   = !(!wr_d && (state_d == SETUP || state_d == ACCESS));
    we_n_d   = !(wr_d && state_d == ACCESS);
    sbe_n_d  = state_d == IDLE ? 2'b11 : be_d;
    ack0_d   = state_d == HOLD && !sel_d;
    ack1_d   = state_d == HOLD && sel_d;
    rdata0_d = last_rd && !sel_q ? iSRAM_RDATA : rdata0_q;
    rdata1_d = last_rd && sel_q ? iSRAM_RDATA : rdata1_q;
  end

  assign oDATA0      = rdata0_q;
  assign oDATA1      = rdata1_q;
  assign oACK0       = ack0_q;
  assign oACK1       = ack1_q;
  assign oSRAM_ADDR  = addr_q;
  assign oSRAM_WDATA = wdata_q;
  assign oSRAM_CE_N  = ce_n_q;
  assign oSRAM_OE_N  = oe_n_q;
  assign oSRAM_WE_N  = we_n_q;
  assign oSRAM_BE_N  = sbe_n_q;
endmodule

// File: tb/tb_sram_arbiter_2port.sv
// tb_sram_arbiter_2port: random and directed checks of the SRAM arbiter against a word-level memory model
module tb_sram_arbiter_2port;
  localparam int W = 1;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  int checks = 0, errors = 0;

  logic req0 = 0, req1 = 0, wr0 = 0, wr1 = 0;
  logic [17:0] a0 = 0, a1 = 0;
  logic [15:0] d0 = 0, d1 = 0;
  logic [1:0] b0 = 0, b1 = 0;
  logic [15:0] q0, q1, swd, srd;
  logic ack0, ack1, ce, oe, we;
  logic [17:0] sa;
  logic [1:0] sbe;

  logic zreq0 = 0, zreq1 = 0, zwr0 = 0, zwr1 = 0;
  logic [17:0] za0 = 0, za1 = 0;
  logic [15:0] zd0 = 0, zd1 = 0;
  logic [1:0] zb0 = 0, zb1 = 0;
  logic [15:0] zq0, zq1, zswd, zsrd;
  logic zack0, zack1, zce, zoe, zwe;
  logic [17:0] zsa;
  logic [1:0] zsbe;

  sram_arbiter_2port #(.WAIT_CYCLES(W)) u_dut (
    .iCLK(clk), .iRST(rst), .iREQ0(req0), .iREQ1(req1), .iWR0(wr0), .iWR1(wr1),
    .iADDR0(a0), .iADDR1(a1), .iDATA0(d0), .iDATA1(d1), .iBE0_N(b0), .iBE1_N(b1),
    .oDATA0(q0), .oDATA1(q1), .oACK0(ack0), .oACK1(ack1), .oSRAM_ADDR(sa),
    .oSRAM_WDATA(swd), .iSRAM_RDATA(srd), .oSRAM_CE_N(ce), .oSRAM_OE_N(oe),
    .oSRAM_WE_N(we), .oSRAM_BE_N(sbe));

  sram_arbiter_2port #(.WAIT_CYCLES(0)) u_dut_w0 (
    .iCLK(clk), .iRST(rst), .iREQ0(zreq0), .iREQ1(zreq1), .iWR0(zwr0), .iWR1(zwr1),
    .iADDR0(za0), .iADDR1(za1), .iDATA0(zd0), .iDATA1(zd1), .iBE0_N(zb0), .iBE1_N(zb1),
    .oDATA0(zq0), .oDATA1(zq1), .oACK0(zack0), .oACK1(zack1), .oSRAM_ADDR(zsa),
    .oSRAM_WDATA(zswd), .iSRAM_RDATA(zsrd), .oSRAM_CE_N(zce), .oSRAM_OE_N(zoe),
    .oSRAM_WE_N(zwe), .oSRAM_BE_N(zsbe));

  // pin-level async SRAM behind each DUT
  logic [15:0] mem [1024];
  logic [15:0] zmem [1024];
  always @(posedge clk) begin
    if (!ce && !we && !sbe[0]) mem[sa[9:0]][7:0] <= swd[7:0];
    if (!ce && !we && !sbe[1]) mem[sa[9:0]][15:8] <= swd[15:8];
    if (!zce && !zwe && !zsbe[0]) zmem[zsa[9:0]][7:0] <= zswd[7:0];
    if (!zce && !zwe && !zsbe[1]) zmem[zsa[9:0]][15:8] <= zswd[15:8];
  end
  assign srd  = (!ce && !oe) ? mem[sa[9:0]] : 16'hBEEF;
  assign zsrd = (!zce && !zoe) ? zmem[zsa[9:0]] : 16'hBEEF;

  // word-level reference: memory contents and the value each port's read data should show
  logic [15:0] ref_mem [1024];
  logic [15:0] exp_q [2];
  bit written [1024];

  function automatic logic [15:0] merge(input logic [15:0] old, input logic [15:0] d, input logic [1:0] be);
    return {be[1] ? old[15:8] : d[15:8], be[0] ? old[7:0] : d[7:0]};
  endfunction

  task automatic drive(input bit p, input bit wr, input logic [17:0] a, input logic [15:0] d, input logic [1:0] be, input bit r);
    if (p) begin req1 = r; wr1 = wr; a1 = a; d1 = d; b1 = be; end
    else begin req0 = r; wr0 = wr; a0 = a; d0 = d; b0 = be; end
  endtask

  task automatic txn(input bit p, input bit wr, input logic [17:0] a, input logic [15:0] d, input logic [1:0] be, input string nm);
    int lat = 0, wel = 0;
    bit got = 0, pins_ok = 1, other = 0;
    drive(p, wr, a, d, be, 1);
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) drive(p, !wr, a ^ 18'h3FF, ~d, ~be, 1);
      if (!we) wel++;
      if (!ce && (sa !== a || sbe !== be || (wr && swd !== d))) pins_ok = 0;
      if (p ? ack0 : ack1) other = 1;
      if (p ? ack1 : ack0) got = 1;
    end
    drive(p, 0, 0, 0, 0, 0);
    if (wr) begin ref_mem[a[9:0]] = merge(ref_mem[a[9:0]], d, be); written[a[9:0]] = 1; end
    else exp_q[p] = ref_mem[a[9:0]];
    checks += 6;
    if (!got || other) begin errors++; $display("FAIL %s ack: got=%0d other=%0d, need got=1 other=0", nm, got, other); end
    if (lat != 3 + W) begin errors++; $display("FAIL %s latency: %0d, need %0d", nm, lat, 3 + W); end
    if (wel != (wr ? W + 1 : 0)) begin errors++; $display("FAIL %s we_low: %0d, need %0d", nm, wel, wr ? W + 1 : 0); end
    if (!pins_ok) begin errors++; $display("FAIL %s pins: addr/be/wdata deviated from latched %h/%b/%h", nm, a, be, d); end
    if (q0 !== exp_q[0]) begin errors++; $display("FAIL %s odata0: %h, need %h", nm, q0, exp_q[0]); end
    if (q1 !== exp_q[1]) begin errors++; $display("FAIL %s odata1: %h, need %h", nm, q1, exp_q[1]); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (2) @(posedge clk);
    #1;
    exp_q[0] = 0; exp_q[1] = 0;
    checks++;
    if ({ce, oe, we, sbe, ack0, ack1, q0, q1, sa, swd} !== {5'b11111, 2'b00, 32'h0, 18'h0, 16'h0}) begin
      errors++;
      $display("FAIL reset: ce/oe/we=%b%b%b be=%b ack=%b%b q=%h/%h addr=%h wd=%h, need 111 11 00 0/0 0 0", ce, oe, we, sbe, ack0, ack1, q0, q1, sa, swd);
    end
    checks++;
    if ({zce, zoe, zwe, zsbe, zack0, zack1, zq0, zq1} !== {5'b11111, 2'b00, 32'h0}) begin errors++; $display("FAIL reset_w0: strobes/ack/q not idle"); end
    rst = 0;
  endtask

  task automatic test_basic;
    txn(0, 1, 18'h00010, 16'hA55A, 2'b00, "wr0_a55a");
    txn(1, 0, 18'h00010, 16'h0000, 2'b00, "rd1_a55a");
    checks++;
    if (q1 !== 16'hA55A) begin errors++; $display("FAIL rd1_const: %h, need a55a", q1); end
    txn(0, 1, 18'h00010, 16'h1234, 2'b10, "wr0_lane");
    txn(0, 0, 18'h00010, 16'h0000, 2'b00, "rd0_lane");
    checks++;
    if (q0 !== 16'hA534) begin errors++; $display("FAIL lane_const: %h, need a534", q0); end
  endtask

  task automatic test_random;
    for (int n = 0; n < 40; n++) begin
      bit p = 1'($urandom_range(0, 1));
      logic [17:0] a = 18'($urandom_range(0, 63));
      bit wr = !written[a[9:0]] || 1'($urandom_range(0, 1));
      logic [1:0] be = written[a[9:0]] ? 2'($urandom_range(0, 3)) : 2'b00;
      txn(p, wr, a, 16'($urandom), be, $sformatf("rand%0d", n));
    end
  endtask

  task automatic test_contention;
    int t [4];
    bit pr [4];
    int n = 0, cyc = 0;
    bit got = 0;
    test_reset;
    drive(0, 0, 18'h00010, 16'h0, 2'b00, 1);
    drive(1, 0, 18'h00010, 16'h0, 2'b00, 1);
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (ack0 && ack1) begin checks++; errors++; $display("FAIL contend_both: two acks at cycle %0d", cyc); end
      if (ack0 || ack1) begin
        t[n] = cyc; pr[n] = ack1; n++;
        checks++;
        if ((ack1 ? q1 : q0) !== ref_mem[16]) begin errors++; $display("FAIL contend_data: %h, need %h", ack1 ? q1 : q0, ref_mem[16]); end
        if (n == 4) req0 = 0;
      end
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL contend_count: %0d acks, need 4", n); end
    for (int i = 0; i < n; i++) begin
`ifdef SRAM_ARB_RR_EN
      bit ep = 1'(i % 2);
`else
      bit ep = 0;
`endif
      checks += 2;
      if (pr[i] !== ep) begin errors++; $display("FAIL contend_order[%0d]: port %0d, need %0d", i, pr[i], ep); end
      if (t[i] != (i == 0 ? 3 + W : t[i - 1] + 4 + W)) begin errors++; $display("FAIL contend_period[%0d]: cycle %0d, need %0d", i, t[i], i == 0 ? 3 + W : t[i - 1] + 4 + W); end
    end
    for (int i = 0; i < 12 && !got; i++) begin
      @(posedge clk); #1;
      if (ack1) got = 1;
    end
    checks++;
    if (!got) begin errors++; $display("FAIL contend_pending: port1 ack=0, need 1"); end
    drive(1, 0, 0, 0, 0, 0);
    exp_q[0] = (n > 0 && !pr[0]) || n > 1 ? ref_mem[16] : 16'h0;
    exp_q[1] = ref_mem[16];
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int lat = 0;
    bit got = 0;
    drive(0, 1, 18'h00020, 16'hC3C3, 2'b00, 1);
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (we !== 1'b0) begin errors++; $display("FAIL mid_pre: we_n=%b, need 0", we); end
    rst = 1;
    @(posedge clk); #1;
    exp_q[0] = 0; exp_q[1] = 0;
    checks++;
    if ({ce, oe, we, sbe, ack0, ack1, sa, swd} !== {5'b11111, 2'b00, 34'h0}) begin
      errors++;
      $display("FAIL mid_reset: ce/oe/we=%b%b%b be=%b ack=%b%b addr=%h wd=%h, need 111 11 00 0 0", ce, oe, we, sbe, ack0, ack1, sa, swd);
    end
    rst = 0;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      lat++;
      if (ack0) got = 1;
    end
    drive(0, 0, 0, 0, 0, 0);
    ref_mem[32] = 16'hC3C3; written[32] = 1;
    checks++;
    if (!got || lat != 3 + W) begin errors++; $display("FAIL mid_reissue: ack=%0d lat=%0d, need 1 %0d", got, lat, 3 + W); end
    @(posedge clk); #1;
    txn(1, 0, 18'h00020, 16'h0, 2'b00, "mid_readback");
  endtask

  task automatic test_wait0;
    int t [3];
    int n = 0, cyc = 0, wel = 0;
    bit got = 0;
    zreq0 = 1; zwr0 = 1; za0 = 18'h00005; zd0 = 16'h5A5A; zb0 = 2'b00;
    for (int i = 0; i < 20 && !got; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (!zwe) wel++;
      if (zack0) got = 1;
    end
    zreq0 = 0;
    checks++;
    if (!got || cyc != 3 || wel != 1) begin errors++; $display("FAIL w0_write: ack=%0d lat=%0d we_low=%0d, need 1 3 1", got, cyc, wel); end
    @(posedge clk); #1;
    cyc = 0;
    zreq1 = 1; zwr1 = 0; za1 = 18'h00005;
    for (int i = 0; i < 30 && n < 3; i++) begin
      @(posedge clk); #1;
      cyc++;
      if (zack1) begin
        t[n] = cyc; n++;
        checks++;
        if (zq1 !== 16'h5A5A) begin errors++; $display("FAIL w0_rdata: %h, need 5a5a", zq1); end
      end
    end
    zreq1 = 0;
    checks++;
    if (n != 3) begin errors++; $display("FAIL w0_count: %0d acks, need 3", n); end
    for (int i = 0; i < n; i++) begin
      checks++;
      if (t[i] != 3 + 4 * i) begin errors++; $display("FAIL w0_timing[%0d]: cycle %0d, need %0d", i, t[i], 3 + 4 * i); end
    end
    @(posedge clk); #1;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ref_mem[i] = 16'h0;
    @(posedge clk); #1;
    test_reset;
    @(posedge clk); #1;
    test_basic;
    test_random;
    test_contention;
    test_reset_mid;
    test_wait0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/sram_arbiter_2port.md
# sram_arbiter_2port

Two-requester controller for the board's 16-bit × 256K asynchronous SRAM. Accepts single-word read/write requests from two host-side clients (port 0: CPU, port 1: video/DMA). Arbitrates between them and sequences the SRAM's CE_N/OE_N/WE_N/BE_N strobes with programmable wait states. Its SRAM-side outputs drive the host side of the existing SRAM pad wrapper, which owns the tristate DQ bus.

## Interface
- WAIT_CYCLES, 1: extra ACCESS-state cycles beyond the first; legal 0..15.
- iCLK  in  1  system clock; all logic on rising edge.
- iRST  in  1  synchronous active-high reset.
- iREQ0 / iREQ1  in  1  request; held high until the matching oACK.
- iWR0 / iWR1  in  1  1 = write, 0 = read.
- iADDR0 / iADDR1  in  18  word address.
- iDATA0 / iDATA1  in  16  write data.
- iBE0_N / iBE1_N  in  2  byte enables, active low; [1] = upper byte, [0] = lower byte.
- oDATA0 / oDATA1  out  16  read data; valid while oACKn = 1, held until that port's next read completes.
- oACK0 / oACK1  out  1  one-cycle completion pulse.
- oSRAM_ADDR  out  18  address to the SRAM wrapper.
- oSRAM_WDATA  out  16  write data to the SRAM wrapper.
- iSRAM_RDATA  in  16  read data from the SRAM wrapper.
- oSRAM_CE_N, oSRAM_OE_N, oSRAM_WE_N  out  1 each  SRAM strobes.
- oSRAM_BE_N  out  2  byte lanes.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD.
- **IDLE**
  - If any iREQn is high, grant one port (see arbitration).
  - Latch that port's address, data, BE_N and WR into internal registers.
  - Go to SETUP.
  - Otherwise stay in IDLE.
- **SETUP** (1 cycle)
  - CE_N = 0.
  - ADDR, BE_N and WDATA are driven from the latched values.
  - Reads: OE_N = 0. Writes: WE_N = 1, OE_N = 1.
- **ACCESS** (WAIT_CYCLES+1 cycles, 4-bit down-counter)
  - Reads: OE_N = 0.
  - Writes: WE_N = 0.
  - On the last ACCESS cycle, a read registers iSRAM_RDATA into the granted port's oDATA.
- **HOLD** (1 cycle)
  - WE_N = 1 and OE_N = 1; CE_N, ADDR and WDATA are unchanged, giving write data hold.
  - oACK of the granted port = 1.
  - Go to IDLE.
- Outside SETUP/ACCESS/HOLD: CE_N = OE_N = WE_N = 1, BE_N = 2'b11, ADDR and WDATA hold their last value.
- Arbitration:
  - When both ports request in the same IDLE cycle: round-robin, or fixed priority (see Configuration).
  - A single requester is always granted.
- Requests are latched at grant; changes to the granted port's inputs after grant have no effect.
- The non-granted port's request stays pending.
- A port whose iREQ is still high in the IDLE cycle following its oACK is treated as a new request.
- Reset (any cycle, including mid-access):
  - Next state is IDLE.
  - All strobes high, BE_N = 2'b11.
  - oACK0 = oACK1 = 0; oDATA0 = oDATA1 = 0; ADDR = 0; WDATA = 0.
  - Round-robin pointer = port 0.
  - An in-flight access is aborted with no ack; the requester re-issues after reset.

## Timing
- iREQ sampled high in IDLE at edge k:
  - SETUP occupies cycle k+1.
  - ACCESS occupies k+2 .. k+2+WAIT_CYCLES.
  - HOLD (oACK high) occupies k+3+WAIT_CYCLES.
- Request-to-ack latency: 3+WAIT_CYCLES cycles.
- Throughput: one access per 4+WAIT_CYCLES cycles (IDLE is a mandatory gap cycle).
- WE_N low pulse width: WAIT_CYCLES+1 cycles.
- Address is stable one cycle before WE_N falls and one cycle after it rises.
- All outputs are registered; no combinational input→output path.

## Configuration
- **SRAM_ARB_RR_EN defined:** round-robin.
  - Contention goes to the port not granted last.
  - The pointer updates on every grant.
- **SRAM_ARB_RR_EN undefined:** fixed priority, port 0 always wins contention; there is no pointer register.

## Structure
- Package sram_arb_pkg holds:
  - ADDR_W = 18 and DATA_W = 16.
  - The state enum (IDLE, SETUP, ACCESS, HOLD).
  - The wait-counter width (4).
- Sub-module sram_arb_grant: 2-way grant logic, with the round-robin pointer under SRAM_ARB_RR_EN.
- The top holds the FSM, the latch registers and the output registers.

## Test plan
- Reset, then port 0 writes 16'hA55A to 18'h00010 with BE_N = 2'b00 (WAIT_CYCLES = 1) -> WE_N low for exactly 2 cycles, oACK0 four cycles after the request edge, model memory holds A55A.
- Port 1 reads 18'h00010 -> oDATA1 = 16'hA55A together with oACK1; oDATA0 unchanged.
- Byte lane: port 0 writes 16'h1234 with BE_N = 2'b10 over 16'hA55A -> readback 16'hA534.
- Both ports request continuously -> with SRAM_ARB_RR_EN, grants alternate 0,1,0,1; without it, only port 0 is served while it keeps requesting.
- Assert iRST in the second ACCESS cycle of a write -> next cycle all strobes high, no oACK, FSM in IDLE; the re-issued write completes normally.
- WAIT_CYCLES = 0 -> read ack 3 cycles after the request, 4-cycle back-to-back period.
